// File: rtl/uart_transceiver.sv
// Byte-wide 8N1 UART: independent transmitter and receiver sharing one clock and reset.
// Bit timing comes from BAUD_DIV system-clock cycles per bit.
module uart_transceiver #(
    parameter int BAUD_DIV = 10417
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       UART_RX,
    input  logic       recv_enable,
    output logic       recv_finish,
    output logic [7:0] readdata,
    input  logic [7:0] writedata,
    input  logic       send_trigger,
    input  logic       send_enable,
    output logic       send_work_state,
    output logic       send_finish,
    output logic       UART_TX
);

    localparam int CNT_W = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BAUD_DIV / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    // ---------------- transmitter ----------------
    logic             trig_sample_r, trig_hist_r, trig_fall_s;
    state_t           tx_state_r, tx_state_nxt_s;
    logic [CNT_W-1:0] tx_cnt_r, tx_cnt_nxt_s;
    logic [2:0]       tx_bit_r, tx_bit_nxt_s;
    logic [7:0]       tx_shift_r, tx_shift_nxt_s;
    logic             tx_line_r, tx_line_nxt_s;
    logic             tx_busy_r, tx_busy_nxt_s;
    logic             tx_done_r, tx_done_nxt_s;

    // History is cleared on reset so a trigger held low through reset never looks like a fall.
    assign trig_fall_s = trig_hist_r & ~trig_sample_r;

    // Trigger sampling and edge history.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            trig_sample_r <= 1'b0;
            trig_hist_r   <= 1'b0;
        end else begin
            trig_sample_r <= send_trigger;
            trig_hist_r   <= trig_sample_r;
        end
    end

    // Transmitter state and registered outputs.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= CNT_ZERO;
            tx_bit_r   <= 3'd0;
            tx_shift_r <= 8'h00;
            tx_line_r  <= 1'b1;
            tx_busy_r  <= 1'b0;
            tx_done_r  <= 1'b0;
        end else begin
            tx_state_r <= tx_state_nxt_s;
            tx_cnt_r   <= tx_cnt_nxt_s;
            tx_bit_r   <= tx_bit_nxt_s;
            tx_shift_r <= tx_shift_nxt_s;
            tx_line_r  <= tx_line_nxt_s;
            tx_busy_r  <= tx_busy_nxt_s;
            tx_done_r  <= tx_done_nxt_s;
        end
    end

    // Transmitter next-state: each state lasts BAUD_DIV cycles; the line value is registered.
    always_comb begin
        tx_state_nxt_s = tx_state_r;
        tx_cnt_nxt_s   = tx_cnt_r;
        tx_bit_nxt_s   = tx_bit_r;
        tx_shift_nxt_s = tx_shift_r;
        tx_line_nxt_s  = tx_line_r;
        tx_busy_nxt_s  = tx_busy_r;
        tx_done_nxt_s  = 1'b0;
        case (tx_state_r)
            ST_IDLE: begin
                tx_line_nxt_s = 1'b1;
                tx_busy_nxt_s = 1'b0;
                tx_cnt_nxt_s  = CNT_ZERO;
                if (trig_fall_s && send_enable) begin
                    tx_state_nxt_s = ST_START;
                    tx_shift_nxt_s = writedata;
                    tx_line_nxt_s  = 1'b0;
                    tx_busy_nxt_s  = 1'b1;
                end else begin
                    tx_state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_nxt_s = ST_DATA;
                    tx_cnt_nxt_s   = CNT_ZERO;
                    tx_bit_nxt_s   = 3'd0;
                    tx_line_nxt_s  = tx_shift_r[0];
                end else begin
                    tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_nxt_s = CNT_ZERO;
                    if (tx_bit_r == 3'd7) begin
                        tx_state_nxt_s = ST_STOP;
                        tx_line_nxt_s  = 1'b1;
                    end else begin
                        tx_bit_nxt_s   = tx_bit_r + 3'd1;
                        tx_shift_nxt_s = {1'b0, tx_shift_r[7:1]};
                        tx_line_nxt_s  = tx_shift_r[1];
                    end
                end else begin
                    tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_nxt_s = ST_IDLE;
                    tx_cnt_nxt_s   = CNT_ZERO;
                    tx_busy_nxt_s  = 1'b0;
                    tx_done_nxt_s  = 1'b1;
                end else begin
                    tx_cnt_nxt_s = tx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                tx_state_nxt_s = ST_IDLE;
                tx_cnt_nxt_s   = CNT_ZERO;
                tx_line_nxt_s  = 1'b1;
                tx_busy_nxt_s  = 1'b0;
            end
        endcase
    end

    assign UART_TX         = tx_line_r;
    assign send_work_state = tx_busy_r;
    assign send_finish     = tx_done_r;

    // ---------------- receiver ----------------
    logic             rx_meta_r, rx_sync_r, rx_prev_r, rx_fall_s;
    state_t           rx_state_r, rx_state_nxt_s;
    logic [CNT_W-1:0] rx_cnt_r, rx_cnt_nxt_s;
    logic [2:0]       rx_bit_r, rx_bit_nxt_s;
    logic [7:0]       rx_shift_r, rx_shift_nxt_s;
    logic [7:0]       rx_data_r, rx_data_nxt_s;
    logic             rx_done_r, rx_done_nxt_s;

    assign rx_fall_s = rx_prev_r & ~rx_sync_r;

    // Two-flop synchronizer plus one history flop for start-edge detection.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= UART_RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // Receiver state and registered outputs.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= CNT_ZERO;
            rx_bit_r   <= 3'd0;
            rx_shift_r <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_done_r  <= 1'b0;
        end else begin
            rx_state_r <= rx_state_nxt_s;
            rx_cnt_r   <= rx_cnt_nxt_s;
            rx_bit_r   <= rx_bit_nxt_s;
            rx_shift_r <= rx_shift_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rx_done_r  <= rx_done_nxt_s;
        end
    end

    // Receiver next-state: half-bit wait validates the start bit, then full-bit steps land mid-bit.
    always_comb begin
        rx_state_nxt_s = rx_state_r;
        rx_cnt_nxt_s   = rx_cnt_r;
        rx_bit_nxt_s   = rx_bit_r;
        rx_shift_nxt_s = rx_shift_r;
        rx_data_nxt_s  = rx_data_r;
        rx_done_nxt_s  = 1'b0;
        case (rx_state_r)
            ST_IDLE: begin
                rx_cnt_nxt_s = CNT_ZERO;
                rx_bit_nxt_s = 3'd0;
                if (rx_fall_s && recv_enable) begin
                    rx_state_nxt_s = ST_START;
                end else begin
                    rx_state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (rx_cnt_r == HALF_LAST) begin
                    rx_cnt_nxt_s = CNT_ZERO;
                    if (!rx_sync_r) begin
                        rx_state_nxt_s = ST_DATA;
                    end else begin
                        rx_state_nxt_s = ST_IDLE;
                    end
                end else begin
                    rx_cnt_nxt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_cnt_nxt_s   = CNT_ZERO;
                    rx_shift_nxt_s = {rx_sync_r, rx_shift_r[7:1]};
                    if (rx_bit_r == 3'd7) begin
                        rx_state_nxt_s = ST_STOP;
                    end else begin
                        rx_bit_nxt_s = rx_bit_r + 3'd1;
                    end
                end else begin
                    rx_cnt_nxt_s = rx_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (rx_cnt_r == BIT_LAST) begin
                    rx_state_nxt_s = ST_IDLE;
                    rx_cnt_nxt_s   = CNT_ZERO;
                    if (rx_sync_r) begin
                        rx_data_nxt_s = rx_shift_r;
                        rx_done_nxt_s = 1'b1;
                    end else begin
                        rx_data_nxt_s = rx_data_r;
                    end
                end else begin
                    rx_cnt_nxt_s = rx_cnt_r + CNT_ONE;
                end
            end
            default: begin
                rx_state_nxt_s = ST_IDLE;
                rx_cnt_nxt_s   = CNT_ZERO;
            end
        endcase
    end

    assign readdata    = rx_data_r;
    assign recv_finish = rx_done_r;

endmodule

// File: tb/tb_uart_transceiver.sv
// Directed self-checking bench for uart_transceiver at BAUD_DIV = 16.
module tb_uart_transceiver;
    localparam int BD = 16;

    logic       sysclk = 1'b0;
    logic       reset;
    logic       rx_drive;
    logic       loop_en;
    logic       rx_line;
    logic       recv_enable;
    logic       recv_finish;
    logic [7:0] readdata;
    logic [7:0] writedata;
    logic       send_trigger;
    logic       send_enable;
    logic       send_work_state;
    logic       send_finish;
    logic       UART_TX;

    int         checks = 0;
    int         errors = 0;
    int         rx_cnt = 0;
    logic [7:0] rx_log [0:15];

    assign rx_line = loop_en ? UART_TX : rx_drive;

    uart_transceiver #(.BAUD_DIV(BD)) dut (
        .sysclk          (sysclk),
        .reset           (reset),
        .UART_RX         (rx_line),
        .recv_enable     (recv_enable),
        .recv_finish     (recv_finish),
        .readdata        (readdata),
        .writedata       (writedata),
        .send_trigger    (send_trigger),
        .send_enable     (send_enable),
        .send_work_state (send_work_state),
        .send_finish     (send_finish),
        .UART_TX         (UART_TX)
    );

    always #5 sysclk = ~sysclk;

    // Record every received byte at its completion pulse.
    always @(negedge sysclk) begin
        if (recv_finish === 1'b1) begin
            if (rx_cnt < 16) rx_log[rx_cnt] = readdata;
            rx_cnt = rx_cnt + 1;
        end
    end

    task automatic drive_rx_frame(input logic [7:0] d, input logic stop_bit);
        rx_drive = 1'b0;
        repeat (BD) @(negedge sysclk);
        for (int k = 0; k < 8; k++) begin
            rx_drive = d[k];
            repeat (BD) @(negedge sysclk);
        end
        rx_drive = stop_bit;
        repeat (BD) @(negedge sysclk);
        rx_drive = 1'b1;
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        repeat (3) @(negedge sysclk);
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", UART_TX); end
        checks++; if (readdata !== 8'h00) begin errors++; $display("FAIL reset_readdata got %h want 00", readdata); end
        checks++; if (send_finish !== 1'b0) begin errors++; $display("FAIL reset_send_finish got %b want 0", send_finish); end
        checks++; if (send_work_state !== 1'b0) begin errors++; $display("FAIL reset_work got %b want 0", send_work_state); end
        checks++; if (recv_finish !== 1'b0) begin errors++; $display("FAIL reset_recv_finish got %b want 0", recv_finish); end
        reset = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sysclk);
            if (UART_TX !== 1'b1 || send_work_state !== 1'b0 || send_finish !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL held_trigger_after_reset got %0d active cycles want 0", bad); end
    endtask

    task automatic test_tx_a5();
        logic [9:0] exp_bits;
        int work_cnt, fin_cnt, fin_at;
        exp_bits = 10'b1101001010;
        work_cnt = 0; fin_cnt = 0; fin_at = -1;
        writedata = 8'hA5; send_enable = 1'b1; send_trigger = 1'b1;
        repeat (3) @(negedge sysclk);
        send_trigger = 1'b0;
        @(negedge sysclk);
        checks++; if (UART_TX !== 1'b1) begin errors++; $display("FAIL tx_latency_early got %b want 1", UART_TX); end
        @(negedge sysclk);
        checks++; if (UART_TX !== 1'b0 || send_work_state !== 1'b1) begin
            errors++; $display("FAIL tx_start got tx=%b work=%b want tx=0 work=1", UART_TX, send_work_state); end
        for (int i = 0; i < 200; i++) begin
            if ((i % BD) == BD / 2 && i < 10 * BD) begin
                checks++;
                if (UART_TX !== exp_bits[i / BD]) begin
                    errors++; $display("FAIL tx_a5_bit%0d got %b want %b", i / BD, UART_TX, exp_bits[i / BD]);
                end
            end
            if (send_work_state === 1'b1) work_cnt++;
            if (send_finish === 1'b1) begin fin_cnt++; fin_at = i; end
            if (i == 40) begin writedata = 8'h00; send_trigger = 1'b1; end
            if (i == 44) send_trigger = 1'b0;
            @(negedge sysclk);
        end
        checks++; if (work_cnt != 160) begin errors++; $display("FAIL tx_work_cycles got %0d want 160", work_cnt); end
        checks++; if (fin_cnt != 1) begin errors++; $display("FAIL tx_finish_count got %0d want 1", fin_cnt); end
        checks++; if (fin_at != 160) begin errors++; $display("FAIL tx_finish_time got %0d want 160", fin_at); end
    endtask

    task automatic test_tx_disabled();
        int bad;
        bad = 0;
        send_enable = 1'b0; send_trigger = 1'b1; writedata = 8'h0F;
        repeat (3) @(negedge sysclk);
        send_trigger = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge sysclk);
            if (UART_TX !== 1'b1 || send_work_state !== 1'b0) bad++;
        end
        send_enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge sysclk);
            if (UART_TX !== 1'b1 || send_work_state !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL tx_disabled got %0d active cycles want 0", bad); end
    endtask

    task automatic test_rx_back_to_back();
        int base;
        base = rx_cnt;
        drive_rx_frame(8'h3C, 1'b1);
        drive_rx_frame(8'hC3, 1'b1);
        repeat (4) @(negedge sysclk);
        checks++; if (rx_cnt - base != 2) begin errors++; $display("FAIL rx_b2b_count got %0d want 2", rx_cnt - base); end
        checks++; if (rx_log[base] !== 8'h3C) begin errors++; $display("FAIL rx_first got %h want 3c", rx_log[base]); end
        checks++; if (rx_log[base + 1] !== 8'hC3) begin errors++; $display("FAIL rx_second got %h want c3", rx_log[base + 1]); end
    endtask

    task automatic test_rx_errors();
        int base;
        base = rx_cnt;
        drive_rx_frame(8'h7E, 1'b0);
        repeat (2 * BD) @(negedge sysclk);
        checks++; if (rx_cnt != base) begin errors++; $display("FAIL rx_framing_pulse got %0d want 0", rx_cnt - base); end
        checks++; if (readdata !== 8'hC3) begin errors++; $display("FAIL rx_framing_hold got %h want c3", readdata); end
        rx_drive = 1'b0;
        repeat (3) @(negedge sysclk);
        rx_drive = 1'b1;
        repeat (2 * BD) @(negedge sysclk);
        checks++; if (rx_cnt != base) begin errors++; $display("FAIL rx_glitch got %0d pulses want 0", rx_cnt - base); end
        recv_enable = 1'b0;
        drive_rx_frame(8'h55, 1'b1);
        repeat (4) @(negedge sysclk);
        recv_enable = 1'b1;
        checks++; if (rx_cnt != base || readdata !== 8'hC3) begin
            errors++; $display("FAIL rx_disabled got %0d pulses data %h want 0 pulses data c3", rx_cnt - base, readdata); end
        drive_rx_frame(8'h96, 1'b1);
        repeat (4) @(negedge sysclk);
        checks++; if (rx_cnt != base + 1 || readdata !== 8'h96) begin
            errors++; $display("FAIL rx_recover got %0d pulses data %h want 1 pulse data 96", rx_cnt - base, readdata); end
    endtask

    task automatic test_loopback();
        int base, waited;
        base = rx_cnt; waited = 0;
        loop_en = 1'b1;
        writedata = 8'h5A; send_trigger = 1'b1;
        repeat (3) @(negedge sysclk);
        send_trigger = 1'b0;
        while (rx_cnt == base && waited < 400) begin
            @(negedge sysclk);
            waited++;
        end
        checks++; if (rx_cnt != base + 1) begin errors++; $display("FAIL loopback_pulse got %0d want 1", rx_cnt - base); end
        checks++; if (readdata !== 8'h5A) begin errors++; $display("FAIL loopback_data got %h want 5a", readdata); end
        repeat (20) @(negedge sysclk);
    endtask

    task automatic test_reset_mid_frame();
        send_trigger = 1'b1;
        repeat (3) @(negedge sysclk);
        send_trigger = 1'b0;
        repeat (2) @(negedge sysclk);
        repeat (60) @(negedge sysclk);
        checks++; if (UART_TX !== 1'b0 || send_work_state !== 1'b1) begin
            errors++; $display("FAIL mid_frame_before got tx=%b work=%b want tx=0 work=1", UART_TX, send_work_state); end
        reset = 1'b1;
        #1;
        checks++; if (UART_TX !== 1'b1 || send_work_state !== 1'b0 || send_finish !== 1'b0) begin
            errors++; $display("FAIL mid_frame_tx got tx=%b work=%b fin=%b want 1 0 0", UART_TX, send_work_state, send_finish); end
        checks++; if (readdata !== 8'h00 || recv_finish !== 1'b0) begin
            errors++; $display("FAIL mid_frame_rx got data=%h fin=%b want 00 0", readdata, recv_finish); end
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        repeat (3) @(negedge sysclk);
    endtask

    initial begin
        reset = 1'b1; rx_drive = 1'b1; loop_en = 1'b0; recv_enable = 1'b1;
        writedata = 8'h00; send_trigger = 1'b0; send_enable = 1'b1;
        test_reset();
        test_tx_a5();
        test_tx_disabled();
        test_rx_back_to_back();
        test_rx_errors();
        test_loopback();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
